// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space invaders game blocks.
// Holds the screen geometry, the player bullet size, the bullet FSM
// state type and the helper that places a freshly fired bullet.
package space_invaders_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] BULLET_W = 10'd4;
  localparam logic [9:0] BULLET_H = 10'd12;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } bullet_state_t;

  // Left edge of a bullet centred on the ship, kept fully on screen so
  // the box never starts left of column 0 or ends right of SCREEN_W-1.
  function automatic logic [9:0] bullet_left_for(input logic [9:0] center);
    logic [9:0] half_w;
    half_w = BULLET_W >> 1;
    if (center < half_w)
      bullet_left_for = 10'd0;
    else if (center > SCREEN_W - half_w)
      bullet_left_for = SCREEN_W - BULLET_W;
    else
      bullet_left_for = center - half_w;
  endfunction

endpackage

// File: rtl/counter.sv
// Generic loadable down-counter.
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset, clears the count
//   load_i       load load_value_i (wins over dec_i)
//   load_value_i value to load
//   dec_i        decrement by one; holds at zero
//   count_o      current count
module counter #(
  parameter int width_p = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_value_i,
  input  logic               dec_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (load_i)
      count_o <= load_value_i;
    else if (dec_i && (count_o != '0))
      count_o <= count_o - width_p'(1);
  end

endmodule

// File: rtl/player_bullet.sv
// Player bullet: launches above the ship on fire, rises once per frame,
// retires on a hit or when it leaves the top of the screen, then waits
// a number of frames before the next shot is accepted. Also renders the
// bullet as a white box for the raster.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   fire_i                  fire button level
//   frame_i                 one-cycle pulse per video frame
//   ship_center_i           player ship centre column
//   hit_i                   bullet struck an enemy
//   pixel_x_i, pixel_y_i    current raster pixel
//   active_o                bullet in flight
//   bullet_*_o (box)        inclusive bullet bounding box
//   bullet_*_o (colour)     registered draw colour for the pixel
module player_bullet
  import space_invaders_pkg::*;
#(
  parameter logic [9:0] ship_top_p        = 10'd440,
  parameter logic [9:0] speed_p           = 10'd4,
  parameter logic [9:0] cooldown_frames_p = 10'd8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       fire_i,
  input  logic       frame_i,
  input  logic [9:0] ship_center_i,
  input  logic       hit_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  output logic       active_o,
  output logic [9:0] bullet_left_o,
  output logic [9:0] bullet_right_o,
  output logic [9:0] bullet_top_o,
  output logic [9:0] bullet_bot_o,
  output logic [3:0] bullet_red_o,
  output logic [3:0] bullet_green_o,
  output logic [3:0] bullet_blue_o
);

  localparam logic [9:0] LAUNCH_TOP = ship_top_p - BULLET_H;

  bullet_state_t state;
  logic [9:0]    cool_count;
  logic          retire;
  logic          cool_done;
  logic          in_box;

  // A hit beats a simultaneous frame pulse; a bullet that cannot rise a
  // full step is treated as having left the screen.
  assign retire = (state == FLYING) &&
                  (hit_i || (frame_i && (bullet_top_o < speed_p)));

  // A zero cooldown leaves immediately; otherwise the pulse that takes
  // the count from 1 to 0 ends the cooldown.
  assign cool_done = (state == COOLDOWN) &&
                     ((cool_count == 10'd0) ||
                      (frame_i && (cool_count == 10'd1)));

  counter #(
    .width_p(10)
  ) u_cooldown (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (retire),
    .load_value_i(cooldown_frames_p),
    .dec_i       ((state == COOLDOWN) && frame_i),
    .count_o     (cool_count)
  );

  assign bullet_right_o = bullet_left_o + (BULLET_W - 10'd1);
  assign bullet_bot_o   = bullet_top_o + (BULLET_H - 10'd1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      active_o      <= 1'b0;
      bullet_left_o <= 10'd0;
      bullet_top_o  <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_i) begin
            state         <= FLYING;
            active_o      <= 1'b1;
            bullet_left_o <= bullet_left_for(ship_center_i);
            bullet_top_o  <= LAUNCH_TOP;
          end
        end
        FLYING: begin
          if (retire) begin
            state    <= COOLDOWN;
            active_o <= 1'b0;
          end else if (frame_i) begin
            bullet_top_o <= bullet_top_o - speed_p;
          end
        end
        COOLDOWN: begin
          if (cool_done)
            state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          active_o <= 1'b0;
        end
      endcase
    end
  end

  assign in_box = active_o &&
                  (pixel_x_i >= bullet_left_o) && (pixel_x_i <= bullet_right_o) &&
                  (pixel_y_i >= bullet_top_o)  && (pixel_y_i <= bullet_bot_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bullet_red_o   <= 4'h0;
      bullet_green_o <= 4'h0;
      bullet_blue_o  <= 4'h0;
    end else begin
      bullet_red_o   <= in_box ? 4'hF : 4'h0;
      bullet_green_o <= in_box ? 4'hF : 4'h0;
      bullet_blue_o  <= in_box ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_player_bullet.sv
// Testbench for player_bullet: directed scenarios plus a randomized run
// checked against a frame-level behavioural model of the bullet.
module tb_player_bullet;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       fire_i;
  logic       frame_i;
  logic [9:0] ship_center_i;
  logic       hit_i;
  logic [9:0] pixel_x_i;
  logic [9:0] pixel_y_i;
  logic       active_o;
  logic [9:0] bullet_left_o;
  logic [9:0] bullet_right_o;
  logic [9:0] bullet_top_o;
  logic [9:0] bullet_bot_o;
  logic [3:0] bullet_red_o;
  logic [3:0] bullet_green_o;
  logic [3:0] bullet_blue_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model: phase 0 waiting, 1 in flight, 2 cooling down
  int m_phase, m_left, m_top, m_cool, m_colour;

  player_bullet dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .fire_i        (fire_i),
    .frame_i       (frame_i),
    .ship_center_i (ship_center_i),
    .hit_i         (hit_i),
    .pixel_x_i     (pixel_x_i),
    .pixel_y_i     (pixel_y_i),
    .active_o      (active_o),
    .bullet_left_o (bullet_left_o),
    .bullet_right_o(bullet_right_o),
    .bullet_top_o  (bullet_top_o),
    .bullet_bot_o  (bullet_bot_o),
    .bullet_red_o  (bullet_red_o),
    .bullet_green_o(bullet_green_o),
    .bullet_blue_o (bullet_blue_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  // Model update for one clock edge with the inputs driven this cycle
  task automatic model_step(input bit rst, input bit fire, input bit frame,
                            input bit hit, input int cx, input int px, input int py);
    int nc;
    nc = (m_phase == 1 && px >= m_left && px <= m_left + 3 &&
          py >= m_top && py <= m_top + 11) ? 15 : 0;
    if (rst) begin
      m_phase = 0; m_left = 0; m_top = 0; m_cool = 0; nc = 0;
    end else begin
      case (m_phase)
        0: if (fire) begin
             m_phase = 1;
             m_left  = (cx < 2) ? 0 : (cx > 638) ? 636 : cx - 2;
             m_top   = 440 - 12;
           end
        1: if (hit) begin
             m_phase = 2; m_cool = 8;
           end else if (frame) begin
             if (m_top < 4) begin
               m_phase = 2; m_cool = 8;
             end else begin
               m_top = m_top - 4;
             end
           end
        default: if (m_cool == 0) begin
             m_phase = 0;
           end else if (frame) begin
             m_cool = m_cool - 1;
             if (m_cool == 0) m_phase = 0;
           end
      endcase
    end
    m_colour = nc;
  endtask

  task automatic test_reset();
    fire_i = 1'b1;
    reset_i = 1'b1;
    tick();
    tick();
    tests_run++;
    if (active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_active: got %0b expected 0", active_o);
    end
    tests_run++;
    if ({bullet_left_o, bullet_top_o} !== {10'd0, 10'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_box: got left %0d top %0d expected 0 0", bullet_left_o, bullet_top_o);
    end
    tests_run++;
    if ({bullet_red_o, bullet_green_o, bullet_blue_o} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_colour: got %h expected 000", {bullet_red_o, bullet_green_o, bullet_blue_o});
    end
    fire_i = 1'b0;
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_launch();
    ship_center_i = 10'd320;
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    tests_run++;
    if (active_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL launch_active: got %0b expected 1", active_o);
    end
    tests_run++;
    if ({bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o} !==
        {10'd318, 10'd321, 10'd428, 10'd439}) begin
      tests_failed++;
      $display("[TB] FAIL launch_box: got %0d %0d %0d %0d expected 318 321 428 439",
               bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o);
    end
  endtask

  task automatic test_flight_exit();
    pulse_frames(107);
    tests_run++;
    if ({active_o, bullet_top_o, bullet_left_o} !== {1'b1, 10'd0, 10'd318}) begin
      tests_failed++;
      $display("[TB] FAIL flight_top0: got active %0b top %0d left %0d expected 1 0 318",
               active_o, bullet_top_o, bullet_left_o);
    end
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    tests_run++;
    if ({active_o, bullet_top_o} !== {1'b0, 10'd0}) begin
      tests_failed++;
      $display("[TB] FAIL exit_retire: got active %0b top %0d expected 0 0", active_o, bullet_top_o);
    end
    fire_i = 1'b1;
    tick();
    pulse_frames(7);
    tests_run++;
    if (active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cooldown_hold: got active %0b expected 0", active_o);
    end
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
    tests_run++;
    if (active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cooldown_last: got active %0b expected 0", active_o);
    end
    tick();
    tests_run++;
    if ({active_o, bullet_top_o} !== {1'b1, 10'd428}) begin
      tests_failed++;
      $display("[TB] FAIL auto_repeat: got active %0b top %0d expected 1 428", active_o, bullet_top_o);
    end
    fire_i = 1'b0;
  endtask

  task automatic test_hit_priority();
    do_reset();
    ship_center_i = 10'd100;
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    pulse_frames(57);
    tests_run++;
    if (bullet_top_o !== 10'd200) begin
      tests_failed++;
      $display("[TB] FAIL hit_setup_top: got %0d expected 200", bullet_top_o);
    end
    hit_i = 1'b1;
    frame_i = 1'b1;
    tick();
    hit_i = 1'b0;
    frame_i = 1'b0;
    tests_run++;
    if ({active_o, bullet_top_o} !== {1'b0, 10'd200}) begin
      tests_failed++;
      $display("[TB] FAIL hit_priority: got active %0b top %0d expected 0 200", active_o, bullet_top_o);
    end
    fire_i = 1'b1;
    repeat (5) tick();
    fire_i = 1'b0;
    tests_run++;
    if (active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fire_in_cooldown: got active %0b expected 0", active_o);
    end
  endtask

  task automatic test_clamp();
    int centers [4] = '{1, 2, 638, 639};
    int lefts   [4] = '{0, 0, 636, 636};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      ship_center_i = 10'(centers[i]);
      hit_i = (i == 0);
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
      hit_i = 1'b0;
      tests_run++;
      if ({active_o, bullet_left_o, bullet_right_o} !==
          {1'b1, 10'(lefts[i]), 10'(lefts[i] + 3)}) begin
        tests_failed++;
        $display("[TB] FAIL clamp_c%0d: got active %0b left %0d right %0d expected 1 %0d %0d",
                 centers[i], active_o, bullet_left_o, bullet_right_o, lefts[i], lefts[i] + 3);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ship_center_i = 10'd320;
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    pulse_frames(32);
    tests_run++;
    if (bullet_top_o !== 10'd300) begin
      tests_failed++;
      $display("[TB] FAIL midflight_setup: got top %0d expected 300", bullet_top_o);
    end
    reset_i = 1'b1;
    fire_i = 1'b1;
    tick();
    tests_run++;
    if ({active_o, bullet_top_o} !== {1'b0, 10'd0}) begin
      tests_failed++;
      $display("[TB] FAIL midflight_reset: got active %0b top %0d expected 0 0", active_o, bullet_top_o);
    end
    tick();
    reset_i = 1'b0;
    tick();
    fire_i = 1'b0;
    tests_run++;
    if ({active_o, bullet_top_o} !== {1'b1, 10'd428}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_launch: got active %0b top %0d expected 1 428", active_o, bullet_top_o);
    end
  endtask

  task automatic test_drawing();
    int xs [5] = '{319, 322, 318, 318, 317};
    int ys [5] = '{430, 430, 439, 440, 435};
    int cs [5] = '{15, 0, 15, 0, 0};
    do_reset();
    ship_center_i = 10'd320;
    pixel_x_i = 10'd319;
    pixel_y_i = 10'd430;
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    tests_run++;
    if (bullet_red_o !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL draw_launch_cycle: got %h expected 0", bullet_red_o);
    end
    for (int i = 0; i < 5; i++) begin
      pixel_x_i = 10'(xs[i]);
      pixel_y_i = 10'(ys[i]);
      tick();
      tests_run++;
      if ({bullet_red_o, bullet_green_o, bullet_blue_o} !== {3{4'(cs[i])}}) begin
        tests_failed++;
        $display("[TB] FAIL draw_%0d_%0d: got %h%h%h expected %0h on each channel",
                 xs[i], ys[i], bullet_red_o, bullet_green_o, bullet_blue_o, cs[i]);
      end
    end
  endtask

  task automatic test_random();
    bit rst, fire, frame, hit;
    int cx, px, py;
    int errs;
    errs = 0;
    reset_i = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst   = ($urandom_range(0, 299) == 0);
      fire  = ($urandom_range(0, 3) == 0);
      frame = ($urandom_range(0, 2) == 0);
      hit   = ($urandom_range(0, 149) == 0);
      cx    = $urandom_range(0, 700);
      if ($urandom_range(0, 1) == 1) begin
        px = m_left + $urandom_range(0, 5) - 1;
        py = m_top + $urandom_range(0, 13) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
      reset_i = rst; fire_i = fire; frame_i = frame; hit_i = hit;
      ship_center_i = 10'(cx); pixel_x_i = 10'(px); pixel_y_i = 10'(py);
      model_step(rst, fire, frame, hit, cx, px, py);
      tick();
      tests_run++;
      if ({active_o, bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o,
           bullet_red_o, bullet_green_o, bullet_blue_o} !==
          {(m_phase == 1), 10'(m_left), 10'(m_left + 3), 10'(m_top), 10'(m_top + 11),
           4'(m_colour), 4'(m_colour), 4'(m_colour)}) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("[TB] FAIL random_cyc%0d: got act %0b box %0d %0d %0d %0d col %h%h%h expected act %0b box %0d %0d %0d %0d col %0h",
                   cyc, active_o, bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o,
                   bullet_red_o, bullet_green_o, bullet_blue_o, (m_phase == 1),
                   m_left, m_left + 3, m_top, m_top + 11, m_colour);
      end
    end
    reset_i = 1'b0; fire_i = 1'b0; frame_i = 1'b0; hit_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    fire_i = 1'b0;
    frame_i = 1'b0;
    hit_i = 1'b0;
    ship_center_i = 10'd0;
    pixel_x_i = 10'd0;
    pixel_y_i = 10'd0;
    test_reset();
    test_launch();
    test_flight_exit();
    test_hit_priority();
    test_clamp();
    test_reset_midflight();
    test_drawing();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
